huff_tree_build: RTL and testbench

//  Receiving end of the req_coding/ack_coding handshake from the symbol frequency counter.

---
 rtl/huff_tree_build.sv | 164 ++++++++++++++++
 tb/tb_huff_tree_build.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/huff_tree_build.sv
// rtl/huff_tree_build.sv - Huffman tree builder fed by the symbol frequency counter.
// Captures ten leaf records and merges the two lightest nodes until one root remains.
module huff_tree_build #(
  parameter int NUM_LEAF = 10,
  parameter int SCAN_LEN = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_coding,
  input  logic [17:0] data_in0,
  input  logic [17:0] data_in1,
  input  logic [17:0] data_in2,
  input  logic [17:0] data_in3,
  input  logic [17:0] data_in4,
  input  logic [17:0] data_in5,
  input  logic [17:0] data_in6,
  input  logic [17:0] data_in7,
  input  logic [17:0] data_in8,
  input  logic [17:0] data_in9,
  output logic        ack_coding,
  output logic        busy,
  output logic        tree_done,
  output logic [4:0]  root_idx,
  output logic        sat,
  input  logic [4:0]  rd_addr,
  output logic [17:0] rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_MERGE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [17:0] tbl [SCAN_LEN];
  logic [7:0]  leaf_freq [NUM_LEAF];
  logic        req_q;
  logic [4:0]  scan_addr;
  logic [3:0]  merge_k;
  logic [3:0]  n_act_q;
  logic        m1_v, m2_v;
  logic [4:0]  m1_a, m2_a;
  logic [7:0]  m1_f, m2_f;
  logic [3:0]  n_act;
  logic [4:0]  first_act;
  logic        capture;
  logic [17:0] cand;
  logic        cand_ok;
  logic [8:0]  sum;
  logic        unused_hi;

  assign leaf_freq[0] = data_in0[7:0];
  assign leaf_freq[1] = data_in1[7:0];
  assign leaf_freq[2] = data_in2[7:0];
  assign leaf_freq[3] = data_in3[7:0];
  assign leaf_freq[4] = data_in4[7:0];
  assign leaf_freq[5] = data_in5[7:0];
  assign leaf_freq[6] = data_in6[7:0];
  assign leaf_freq[7] = data_in7[7:0];
  assign leaf_freq[8] = data_in8[7:0];
  assign leaf_freq[9] = data_in9[7:0];
  assign unused_hi = ^{data_in0[17:8], data_in1[17:8], data_in2[17:8], data_in3[17:8],
                       data_in4[17:8], data_in5[17:8], data_in6[17:8], data_in7[17:8],
                       data_in8[17:8], data_in9[17:8]};

  always_comb begin
    n_act     = 4'd0;
    first_act = 5'd0;
    for (int i = NUM_LEAF - 1; i >= 0; i--) begin
      if (leaf_freq[i] != 8'd0) begin
        n_act     = n_act + 4'd1;
        first_act = 5'(i);
      end
    end
  end

  // Rising edge only: a request held through a build must not recapture.
  assign capture   = (state == S_IDLE) && req_coding && !req_q;
  assign busy      = (state != S_IDLE);
  assign tree_done = (state == S_DONE);
  assign rd_data   = (rd_addr < 5'(SCAN_LEN)) ? tbl[rd_addr] : 18'd0;

  // Internal nodes only count once created, i.e. index below the current merge number.
  assign cand    = tbl[scan_addr];
  assign cand_ok = !cand[17] &&
                   ((scan_addr < 5'(NUM_LEAF)) ? (cand[7:0] != 8'd0)
                                               : ((scan_addr - 5'(NUM_LEAF)) < {1'b0, merge_k}));
  assign sum     = {1'b0, m1_f} + {1'b0, m2_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_q      <= 1'b0;
      ack_coding <= 1'b0;
      root_idx   <= 5'd0;
      sat        <= 1'b0;
      scan_addr  <= 5'd0;
      merge_k    <= 4'd0;
      n_act_q    <= 4'd0;
      m1_v       <= 1'b0;
      m2_v       <= 1'b0;
      m1_a       <= 5'd0;
      m2_a       <= 5'd0;
      m1_f       <= 8'd0;
      m2_f       <= 8'd0;
      for (int i = 0; i < SCAN_LEN; i++) tbl[i] <= 18'd0;
    end else begin
      req_q      <= req_coding;
      ack_coding <= capture;
      case (state)
        S_IDLE: begin
          if (capture) begin
            for (int i = 0; i < NUM_LEAF; i++) tbl[i] <= {6'd0, 4'(i), leaf_freq[i]};
            for (int i = NUM_LEAF; i < SCAN_LEN; i++) tbl[i] <= 18'd0;
            sat       <= 1'b0;
            n_act_q   <= n_act;
            merge_k   <= 4'd0;
            scan_addr <= 5'd0;
            m1_v      <= 1'b0;
            m2_v      <= 1'b0;
            root_idx  <= (n_act < 4'd2) ? first_act : 5'd0;
            state     <= (n_act < 4'd2) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (cand_ok) begin
            if (!m1_v || cand[7:0] < m1_f) begin
              m2_v <= m1_v;
              m2_a <= m1_a;
              m2_f <= m1_f;
              m1_v <= 1'b1;
              m1_a <= scan_addr;
              m1_f <= cand[7:0];
            end else if (!m2_v || cand[7:0] < m2_f) begin
              m2_v <= 1'b1;
              m2_a <= scan_addr;
              m2_f <= cand[7:0];
            end
          end
          if (scan_addr == 5'(SCAN_LEN - 1)) state <= S_MERGE;
          else scan_addr <= scan_addr + 5'd1;
        end
        S_MERGE: begin
          tbl[m1_a] <= {1'b1, merge_k, 1'b0, tbl[m1_a][11:0]};
          tbl[m2_a] <= {1'b1, merge_k, 1'b1, tbl[m2_a][11:0]};
          tbl[5'(NUM_LEAF) + {1'b0, merge_k}] <= {6'd0, merge_k, sum[8] ? 8'hFF : sum[7:0]};
          if (sum[8]) sat <= 1'b1;
          scan_addr <= 5'd0;
          m1_v      <= 1'b0;
          m2_v      <= 1'b0;
          merge_k   <= merge_k + 4'd1;
          if (merge_k == n_act_q - 4'd2) begin
            root_idx <= 5'(NUM_LEAF) + {1'b0, merge_k};
            state    <= S_DONE;
          end else begin
            state <= S_SCAN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_tree_build.sv
// tb/tb_huff_tree_build.sv - Randomized and directed bench for huff_tree_build.
// Expected trees come from a selection-by-key model of the merge rules.
module tb_huff_tree_build;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_coding = 1'b0;
  logic [17:0] din [10];
  logic        ack_coding, busy, tree_done, sat;
  logic [4:0]  root_idx;
  logic [4:0]  rd_addr = 5'd0;
  logic [17:0] rd_data;

  huff_tree_build dut (
    .clk(clk), .rst(rst), .req_coding(req_coding),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
    .data_in8(din[8]), .data_in9(din[9]),
    .ack_coding(ack_coding), .busy(busy), .tree_done(tree_done), .root_idx(root_idx),
    .sat(sat), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int lf [10];
  int mf [19];
  int mp [19];
  int mpar [19];
  int mbit [19];
  int mnum [19];
  int exp_n, exp_root, exp_sat;
  int last_root;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Smallest (freq, address) among live nodes, skipping excl.
  function automatic int pick(input int k, input int excl);
    int best = -1;
    int best_key = 0;
    for (int a = 0; a < 19; a++) begin
      bit live = (mp[a] == 0) && (a != excl) && ((a < 10) ? (mf[a] != 0) : (a - 10 < k));
      if (live && (best < 0 || mf[a] * 32 + a < best_key)) begin
        best = a;
        best_key = mf[a] * 32 + a;
      end
    end
    return best;
  endfunction

  task automatic model_build();
    int a1, a2, s;
    exp_n = 0;
    exp_sat = 0;
    exp_root = 0;
    for (int a = 0; a < 19; a++) begin
      mp[a] = 0; mpar[a] = 0; mbit[a] = 0;
      mnum[a] = (a < 10) ? a : 0;
      mf[a] = (a < 10) ? (lf[a] & 255) : 0;
    end
    for (int a = 9; a >= 0; a--) if (mf[a] != 0) begin exp_n++; exp_root = a; end
    if (exp_n < 2) return;
    for (int k = 0; k <= exp_n - 2; k++) begin
      a1 = pick(k, -1);
      a2 = pick(k, a1);
      mp[a1] = 1; mpar[a1] = k; mbit[a1] = 0;
      mp[a2] = 1; mpar[a2] = k; mbit[a2] = 1;
      s = mf[a1] + mf[a2];
      if (s > 255) begin s = 255; exp_sat = 1; end
      mf[10 + k] = s;
      mnum[10 + k] = k;
    end
    exp_root = 10 + exp_n - 2;
  endtask

  task automatic check_table(input string tag);
    logic [17:0] e;
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1;
      if (a < 19) e = {mp[a][0], mpar[a][3:0], mbit[a][0], mnum[a][3:0], mf[a][7:0]};
      else e = 18'd0;
      check($sformatf("%s_rec%0d", tag, a), 32'(rd_data), 32'(e));
    end
  endtask

  task automatic run_case(input string tag, input bit hold);
    int exp_done, acks, dones, ack_c, done_c;
    model_build();
    exp_done = (exp_n >= 2) ? 20 * (exp_n - 1) + 1 : 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) din[i] = {10'($urandom), lf[i][7:0]};
    req_coding = 1'b1;
    acks = 0; dones = 0; ack_c = -1; done_c = -1;
    for (int cyc = 1; cyc <= exp_done + 6; cyc++) begin
      @(negedge clk);
      if (!hold) req_coding = 1'b0;
      if (cyc == 1) check({tag, "_busy1"}, 32'(busy), 32'd1);
      if (ack_coding) begin acks++; ack_c = cyc; end
      if (tree_done) begin
        dones++;
        done_c = cyc;
        last_root = int'(root_idx);
        check({tag, "_root"}, 32'(root_idx), 32'(exp_root));
      end
    end
    req_coding = 1'b0;
    check({tag, "_ack_cyc"}, 32'(ack_c), 32'd1);
    check({tag, "_acks"}, 32'(acks), 32'd1);
    check({tag, "_dones"}, 32'(dones), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_c), 32'(exp_done));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    check_table(tag);
  endtask

  task automatic set_lf(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    lf[0] = a0; lf[1] = a1; lf[2] = a2; lf[3] = a3; lf[4] = a4;
    lf[5] = a5; lf[6] = a6; lf[7] = a7; lf[8] = a8; lf[9] = a9;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) din[i] = 18'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", 32'(ack_coding), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tree_done), 32'd0);
    check("rst_root", 32'(root_idx), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    for (int a = 0; a < 19; a++) mf[a] = 0;

    set_lf(5, 9, 12, 13, 16, 45, 0, 0, 0, 0);
    run_case("t1", 1'b0);
    check("t1_root_const", 32'(last_root), 32'd14);
    rd_addr = 5'd13; #1;
    check("t1_i3_freq", 32'(rd_data[7:0]), 32'd55);

    set_lf(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    run_case("t2", 1'b0);
    check("t2_root_const", 32'(last_root), 32'd18);

    set_lf(200, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    run_case("t3", 1'b0);
    check("t3_sat_const", 32'(sat), 32'd1);

    set_lf(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    run_case("t4a", 1'b0);
    check("t4a_root_const", 32'(last_root), 32'd3);
    set_lf(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_case("t4b", 1'b0);

    set_lf(3, 8, 2, 8, 0, 1, 9, 4, 4, 6);
    @(negedge clk);
    for (int i = 0; i < 10; i++) din[i] = {10'd0, lf[i][7:0]};
    req_coding = 1'b1;
    @(negedge clk);
    req_coding = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ack", 32'(ack_coding), 32'd0);
    check("t5_done", 32'(tree_done), 32'd0);
    check("t5_root", 32'(root_idx), 32'd0);
    for (int a = 0; a < 19; a++) begin mp[a] = 0; mpar[a] = 0; mbit[a] = 0; mnum[a] = 0; mf[a] = 0; end
    check_table("t5_clr");
    run_case("t5_fresh", 1'b0);

    set_lf(7, 3, 0, 11, 2, 0, 5, 5, 0, 1);
    run_case("t6", 1'b1);

    for (int it = 0; it < 20; it++) begin
      int hi = (it % 3 == 0) ? 4 : ((it % 3 == 1) ? 255 : 40);
      for (int i = 0; i < 10; i++)
        lf[i] = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, hi));
      run_case($sformatf("rnd%0d", it), it % 5 == 4);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
